// File: rtl/pa_store_range.sv
// Stores a valid/ready sample stream into RAM addresses si..ei inclusive,
// one word per accepted sample, with a one-cycle registered write port.
module pa_store_range #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start_store,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_addr_si,
    input  logic [ADDR_WIDTH-1:0] i_addr_ei,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_we_ram,
    output logic [ADDR_WIDTH-1:0] o_addr_ram,
    output logic [DATA_WIDTH-1:0] o_data_ram,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err_range,
    output logic [ADDR_WIDTH:0]   o_count
);

    // Handshake: a sample is transferred in any cycle where i_valid && o_ready
    // are both high at the rising edge; o_ready is high exactly while in WRITE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_ei;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_done;
    logic                    r_err;
    logic [ADDR_WIDTH:0]     r_count;

    logic w_xfer;
    logic w_last;
    logic w_start_ok;
    logic w_start_bad;

    assign w_xfer      = (r_state == ST_WRITE) && i_valid;
    // End-of-range is compared before the pointer increments, so ei = max never wraps.
    assign w_last      = w_xfer && (r_ptr == r_ei);
    assign w_start_ok  = (r_state == ST_IDLE) && i_start_store && (i_addr_ei >= i_addr_si);
    assign w_start_bad = (r_state == ST_IDLE) && i_start_store && (i_addr_ei <  i_addr_si);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Abort wins over end-of-range; the coinciding transfer is still written.
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ei    <= '0;
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            r_we   <= w_xfer;
            r_done <= (r_state == ST_DONE);
            r_err  <= w_start_bad;
            if (w_start_ok) begin
                r_ei    <= i_addr_ei;
                r_ptr   <= i_addr_si;
                r_count <= '0;
            end
            if (w_xfer) begin
                r_addr  <= r_ptr;
                r_data  <= i_data;
                r_ptr   <= r_ptr + 1'b1;
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_ready     = (r_state == ST_WRITE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_we_ram    = r_we;
    assign o_addr_ram  = r_addr;
    assign o_data_ram  = r_data;
    assign o_done      = r_done;
    assign o_err_range = r_err;
    assign o_count     = r_count;

endmodule

// File: tb/tb_pa_store_range.sv
// Directed bench for pa_store_range: hand-computed expectations checked with
// immediate assertions after every clock edge.
module tb_pa_store_range;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_start_store;
    logic          i_abort;
    logic [AW-1:0] i_addr_si;
    logic [AW-1:0] i_addr_ei;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_ready;
    logic          o_we_ram;
    logic [AW-1:0] o_addr_ram;
    logic [DW-1:0] o_data_ram;
    logic          o_busy;
    logic          o_done;
    logic          o_err_range;
    logic [AW:0]   o_count;

    int total;
    int bad;

    pa_store_range #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_start_store (i_start_store),
        .i_abort       (i_abort),
        .i_addr_si     (i_addr_si),
        .i_addr_ei     (i_addr_ei),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_ready       (o_ready),
        .o_we_ram      (o_we_ram),
        .o_addr_ram    (o_addr_ram),
        .o_data_ram    (o_data_ram),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err_range   (o_err_range),
        .o_count       (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check({tag, "_we"},   32'(o_we_ram),   32'd1);
        check({tag, "_addr"}, 32'(o_addr_ram), 32'(a));
        check({tag, "_data"}, 32'(o_data_ram), 32'(d));
    endtask

    task automatic start(input logic [AW-1:0] si, input logic [AW-1:0] ei);
        i_start_store = 1'b1;
        i_addr_si     = si;
        i_addr_ei     = ei;
        tick();
        i_start_store = 1'b0;
        i_addr_si     = 6'd33;
        i_addr_ei     = 6'd1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        i_rst_n       = 1'b0;
        i_start_store = 1'b0;
        i_abort       = 1'b0;
        i_addr_si     = '0;
        i_addr_ei     = '0;
        i_valid       = 1'b0;
        i_data        = '0;
        tick();
        tick();
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_busy",  32'(o_busy),  32'd0);
        check("rst_we",    32'(o_we_ram), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_done",  32'(o_done),  32'd0);
        check("rst_err",   32'(o_err_range), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        // Range 4..7 with valid held high.
        start(6'd4, 6'd7);
        check("t1_busy",  32'(o_busy),   32'd1);
        check("t1_ready", 32'(o_ready),  32'd1);
        check("t1_we0",   32'(o_we_ram), 32'd0);
        check("t1_cnt0",  32'(o_count),  32'd0);
        i_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_data = 8'(10 + k);
            tick();
            check_write("t1_w", 6'(4 + k), 8'(10 + k));
            check("t1_cnt", 32'(o_count), 32'(k + 1));
        end
        i_valid = 1'b0;
        check("t1_ready_last", 32'(o_ready), 32'd0);
        check("t1_done_early", 32'(o_done),  32'd0);
        tick();
        check("t1_done",  32'(o_done),    32'd1);
        check("t1_we_off", 32'(o_we_ram), 32'd0);
        check("t1_busy_end", 32'(o_busy), 32'd0);
        check("t1_addr_hold", 32'(o_addr_ram), 32'd7);
        check("t1_count", 32'(o_count),   32'd4);
        tick();
        check("t1_done_pulse", 32'(o_done), 32'd0);

        // Full range 0..63, valid every other cycle.
        start(6'd0, 6'd63);
        for (int k = 0; k < 64; k++) begin
            i_valid = 1'b1;
            i_data  = 8'(k + 100);
            tick();
            check_write("t2_w", 6'(k), 8'(k + 100));
            if (k != 63) begin
                i_valid = 1'b0;
                i_data  = 8'hFF;
                tick();
                check("t2_gap_we", 32'(o_we_ram), 32'd0);
            end
        end
        i_valid = 1'b0;
        check("t2_ready_last", 32'(o_ready), 32'd0);
        check("t2_count", 32'(o_count), 32'd64);
        tick();
        check("t2_done", 32'(o_done), 32'd1);
        check("t2_we_off", 32'(o_we_ram), 32'd0);
        check("t2_addr_hold", 32'(o_addr_ram), 32'd63);
        tick();

        // Rejected range.
        start(6'd9, 6'd3);
        check("t3_err",   32'(o_err_range), 32'd1);
        check("t3_busy",  32'(o_busy),      32'd0);
        check("t3_count", 32'(o_count),     32'd64);
        tick();
        check("t3_err_pulse", 32'(o_err_range), 32'd0);
        check("t3_we",        32'(o_we_ram),    32'd0);

        // Single-word range.
        start(6'd5, 6'd5);
        i_valid = 1'b1;
        i_data  = 8'hAA;
        tick();
        i_valid = 1'b0;
        check_write("t4_w", 6'd5, 8'hAA);
        check("t4_done_early", 32'(o_done), 32'd0);
        tick();
        check("t4_done",  32'(o_done),  32'd1);
        check("t4_count", 32'(o_count), 32'd1);

        // Abort after six transfers, valid high on the abort cycle.
        tick();
        start(6'd0, 6'd15);
        i_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i_data = 8'(k + 50);
            tick();
            check_write("t5_w", 6'(k), 8'(k + 50));
        end
        i_abort = 1'b1;
        i_data  = 8'd56;
        tick();
        i_abort = 1'b0;
        i_valid = 1'b0;
        check_write("t5_abort_w", 6'd6, 8'd56);
        check("t5_busy",  32'(o_busy),  32'd0);
        check("t5_ready", 32'(o_ready), 32'd0);
        check("t5_count", 32'(o_count), 32'd7);
        start(6'd1, 6'd2);
        check("t5_restart_busy",  32'(o_busy),  32'd1);
        check("t5_restart_count", 32'(o_count), 32'd0);
        check("t5_no_done",       32'(o_done),  32'd0);

        // Reset in the middle of a run, then a clean restart.
        i_valid = 1'b1;
        i_data  = 8'h3C;
        tick();
        check_write("t6_pre", 6'd1, 8'h3C);
        i_rst_n = 1'b0;
        #1;
        check("t6_rst_we",    32'(o_we_ram),   32'd0);
        check("t6_rst_busy",  32'(o_busy),     32'd0);
        check("t6_rst_ready", 32'(o_ready),    32'd0);
        check("t6_rst_addr",  32'(o_addr_ram), 32'd0);
        check("t6_rst_data",  32'(o_data_ram), 32'd0);
        check("t6_rst_count", 32'(o_count),    32'd0);
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        start(6'd2, 6'd3);
        i_valid = 1'b1;
        i_data  = 8'h21;
        tick();
        check_write("t6_w0", 6'd2, 8'h21);
        i_data = 8'h22;
        tick();
        check_write("t6_w1", 6'd3, 8'h22);
        i_valid = 1'b0;
        tick();
        check("t6_done",  32'(o_done),  32'd1);
        check("t6_count", 32'(o_count), 32'd2);
        check("t6_busy",  32'(o_busy),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
